// File: rtl/svm_slice_acc.sv
// SVM slice accumulator: multiplies each sample by its coefficient, builds per-slice sums,
// folds them into a per-window circular buffer and emits a biased, saturated score.
module svm_slice_acc #(
    parameter int DWIDTH  = 8,
    parameter int CWIDTH  = 9,
    parameter int AWIDTH  = 32,
    parameter int WINCOLS = 8,
    parameter int WPI     = 40,
    parameter int SLICES  = 8
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     dvi,
    input  logic [DWIDTH-1:0]        data,
    input  logic signed [CWIDTH-1:0] svcoeff,
    input  logic                     newblock,
    input  logic signed [AWIDTH-1:0] bias,
    input  logic                     clear,
    output logic                     busy,
    output logic                     dvo,
    output logic signed [AWIDTH-1:0] score,
    output logic                     msb,
    output logic                     sat
);

    localparam int PW   = DWIDTH + CWIDTH + 1;
    // Adds run wide enough for either operand plus a carry, so nothing wraps before the clamp.
    localparam int EW   = ((PW > AWIDTH) ? PW : AWIDTH) + 1;
    localparam int CNTW = (SLICES > 1) ? $clog2(SLICES) : 1;
    localparam int BCW  = (WINCOLS > 1) ? $clog2(WINCOLS) : 1;
    localparam int PTRW = $clog2(WPI);

    localparam logic [BCW-1:0]           BC_LAST  = BCW'(WINCOLS - 1);
    localparam logic [CNTW-1:0]          CNT_LAST = CNTW'(SLICES - 1);
    localparam logic [PTRW-1:0]          PTR_LAST = PTRW'(WPI - 1);
    localparam logic signed [AWIDTH-1:0] AMAX     = {1'b0, {(AWIDTH-1){1'b1}}};
    localparam logic signed [AWIDTH-1:0] AMIN     = {1'b1, {(AWIDTH-1){1'b0}}};

    function automatic logic sat_ovf(input logic signed [EW-1:0] x);
        logic signed [EW-1:0] hi;
        logic signed [EW-1:0] lo;
        hi = EW'(AMAX);
        lo = EW'(AMIN);
        return (x > hi) || (x < lo);
    endfunction

    function automatic logic signed [AWIDTH-1:0] sat_val(input logic signed [EW-1:0] x);
        logic signed [EW-1:0] hi;
        logic signed [EW-1:0] lo;
        hi = EW'(AMAX);
        lo = EW'(AMIN);
        if (x > hi)      return AMAX;
        else if (x < lo) return AMIN;
        else             return x[AWIDTH-1:0];
    endfunction

    typedef enum logic {S_CLEAR, S_RUN} state_t;

    state_t                     state_q, state_d;
    logic [PTRW-1:0]            caddr_q, caddr_d;
    logic [BCW-1:0]             blockcount_q, blockcount_d;
    logic [PTRW-1:0]            ptr_q;
    logic signed [AWIDTH-1:0]   tmp_q;
    logic signed [AWIDTH-1:0]   score_q;
    logic                       msb_q, dvo_q, sat_q;

    logic                       vld_p1, last_p1;
    logic signed [PW-1:0]       prod_p1;

    logic [CNTW-1:0]            cnt_mem [WPI];
    logic signed [AWIDTH-1:0]   sum_mem [WPI];

    // FSM: CLEAR sweeps the buffer once, RUN accepts samples
    always_comb begin
        state_d = state_q;
        caddr_d = caddr_q;
        if (clear) begin
            state_d = S_CLEAR;
            caddr_d = '0;
        end else if (state_q == S_CLEAR) begin
            if (caddr_q == PTR_LAST) begin
                state_d = S_RUN;
                caddr_d = '0;
            end else begin
                caddr_d = caddr_q + 1'b1;
            end
        end
    end

    // Stage 0: sample acceptance and block counting
    logic take0, last0;
    assign take0 = dvi && (state_q == S_RUN) && !clear;
    assign last0 = newblock && (blockcount_q == BC_LAST);

    always_comb begin
        blockcount_d = blockcount_q;
        if (clear)
            blockcount_d = '0;
        else if (take0 && newblock)
            blockcount_d = (blockcount_q == BC_LAST) ? '0 : blockcount_q + 1'b1;
    end

    // Stage 1: product register (data path, no reset)
    logic signed [PW-1:0] dx_p0, cx_p0;
    assign dx_p0 = PW'($signed({1'b0, data}));
    assign cx_p0 = PW'(svcoeff);

    always_ff @(posedge clk) begin
        prod_p1 <= dx_p0 * cx_p0;
    end

    // Stage 2: accumulate, fold into buffer, produce score
    logic signed [EW-1:0]     acc_x, n_x, sc_x;
    logic signed [AWIDTH-1:0] s_val, n_val, sc_val;
    logic                     s_ovf, n_ovf, sc_ovf;
    logic [CNTW-1:0]          rd_cnt;
    logic signed [AWIDTH-1:0] rd_sum;
    logic                     emit, ovf_p1;

    always_comb begin
        acc_x  = EW'(tmp_q) + EW'(prod_p1);
        s_val  = sat_val(acc_x);
        s_ovf  = sat_ovf(acc_x);
        rd_cnt = cnt_mem[ptr_q];
        rd_sum = sum_mem[ptr_q];
        n_x    = EW'(rd_sum) + EW'(s_val);
        n_val  = sat_val(n_x);
        n_ovf  = sat_ovf(n_x);
        sc_x   = EW'(n_val) + EW'(bias);
        sc_val = sat_val(sc_x);
        sc_ovf = sat_ovf(sc_x);
        emit   = vld_p1 && last_p1 && (rd_cnt == CNT_LAST);
        ovf_p1 = vld_p1 && (s_ovf || (last_p1 && (n_ovf || ((rd_cnt == CNT_LAST) && sc_ovf))));
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= S_CLEAR;
            caddr_q      <= '0;
            blockcount_q <= '0;
            ptr_q        <= '0;
            tmp_q        <= '0;
            vld_p1       <= 1'b0;
            last_p1      <= 1'b0;
            dvo_q        <= 1'b0;
            score_q      <= '0;
            msb_q        <= 1'b0;
            sat_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            caddr_q      <= caddr_d;
            blockcount_q <= blockcount_d;
            vld_p1       <= take0;
            last_p1      <= last0;
            if (clear) begin
                tmp_q <= '0;
                ptr_q <= '0;
                sat_q <= 1'b0;
                dvo_q <= 1'b0;
            end else begin
                dvo_q <= emit;
                if (ovf_p1)
                    sat_q <= 1'b1;
                if (vld_p1) begin
                    if (!last_p1) begin
                        tmp_q <= s_val;
                    end else begin
                        tmp_q <= '0;
                        ptr_q <= (ptr_q == PTR_LAST) ? '0 : ptr_q + 1'b1;
                    end
                end
                if (emit) begin
                    score_q <= sc_val;
                    msb_q   <= !sc_val[AWIDTH-1] && (sc_val != '0);
                end
            end
        end
    end

    // Partial-sum buffer: register array, rewritten wholesale by the CLEAR sweep
    always_ff @(posedge clk) begin
        if (state_q == S_CLEAR) begin
            cnt_mem[caddr_q] <= '0;
            sum_mem[caddr_q] <= '0;
        end else if (!clear && vld_p1 && last_p1) begin
            if (emit) begin
                cnt_mem[ptr_q] <= '0;
                sum_mem[ptr_q] <= '0;
            end else begin
                cnt_mem[ptr_q] <= rd_cnt + 1'b1;
                sum_mem[ptr_q] <= n_val;
            end
        end
    end

    assign busy  = (state_q == S_CLEAR);
    assign dvo   = dvo_q;
    assign score = score_q;
    assign msb   = msb_q;
    assign sat   = sat_q;

endmodule

// File: tb/tb_svm_slice_acc.sv
// Bench for svm_slice_acc: directed scenarios plus a random stream, checked every cycle
// against a per-window arithmetic model for a 32-bit and a 12-bit accumulator instance.
module tb_svm_slice_acc;

    localparam int DW  = 8;
    localparam int CW  = 9;
    localparam int AW  = 32;
    localparam int AW2 = 12;
    localparam int WC  = 2;
    localparam int WP  = 3;
    localparam int SL  = 2;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    logic                 dvi = 1'b0;
    logic [DW-1:0]        data = '0;
    logic signed [CW-1:0] svcoeff = '0;
    logic                 newblock = 1'b0;
    logic signed [AW-1:0] bias = '0;
    logic                 clear = 1'b0;

    logic                  busy, dvo, msb, sat;
    logic signed [AW-1:0]  score;
    logic                  busy2, dvo2, msb2, sat2;
    logic signed [AW2-1:0] score2;

    svm_slice_acc #(.DWIDTH(DW), .CWIDTH(CW), .AWIDTH(AW), .WINCOLS(WC), .WPI(WP), .SLICES(SL)) dut (
        .clk(clk), .reset_n(reset_n), .dvi(dvi), .data(data), .svcoeff(svcoeff),
        .newblock(newblock), .bias(bias), .clear(clear), .busy(busy), .dvo(dvo),
        .score(score), .msb(msb), .sat(sat)
    );

    svm_slice_acc #(.DWIDTH(DW), .CWIDTH(CW), .AWIDTH(AW2), .WINCOLS(WC), .WPI(WP), .SLICES(SL)) dut12 (
        .clk(clk), .reset_n(reset_n), .dvi(dvi), .data(data), .svcoeff(svcoeff),
        .newblock(newblock), .bias(bias[AW2-1:0]), .clear(clear), .busy(busy2), .dvo(dvo2),
        .score(score2), .msb(msb2), .sat(sat2)
    );

    int errors = 0;
    int checks = 0;

    // Reference model state, index 0 = 32-bit instance, 1 = 12-bit instance
    longint m_tmp [2];
    longint m_psum [2][WP];
    int     m_cnt [2][WP];
    longint m_score [2];
    bit     m_msb [2];
    bit     m_sat [2];
    int     m_bc = 0;
    int     m_ptr = 0;
    int     m_busy = WP;
    // Expectation for the outputs after the next clock edge
    bit     p_dvo [2];
    longint p_score [2];
    bit     p_msb [2];
    bit     p_sat [2];

    int     n_dvo = 0;
    int     n_dvo2 = 0;
    longint last_sc = 0;
    longint last_sc2 = 0;

    task automatic chk(input string tag, input longint obs, input longint exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic longint sadd(input int i, input longint x);
        int     aw;
        longint hi, lo;
        aw = (i == 0) ? AW : AW2;
        hi = (longint'(1) << (aw - 1)) - 1;
        lo = -(longint'(1) << (aw - 1));
        if (x > hi) begin m_sat[i] = 1'b1; return hi; end
        if (x < lo) begin m_sat[i] = 1'b1; return lo; end
        return x;
    endfunction

    task automatic model_wipe();
        for (int i = 0; i < 2; i++) begin
            m_tmp[i] = 0;
            m_sat[i] = 1'b0;
            for (int w = 0; w < WP; w++) begin
                m_psum[i][w] = 0;
                m_cnt[i][w]  = 0;
            end
        end
        m_bc  = 0;
        m_ptr = 0;
    endtask

    task automatic cycle(input bit v, input int d, input int c, input bit nb, input bit clr);
        bit     acc, last;
        bit     ed [2];
        bit     xd [2], xs [2], xm [2];
        longint xsc [2];
        longint prod, s, n, sc, b;
        dvi      = v;
        data     = DW'(d);
        svcoeff  = CW'(c);
        newblock = nb;
        clear    = clr;
        for (int i = 0; i < 2; i++) begin
            xd[i]  = clr ? 1'b0 : p_dvo[i];
            xs[i]  = clr ? 1'b0 : p_sat[i];
            xm[i]  = p_msb[i];
            xsc[i] = p_score[i];
            ed[i]  = 1'b0;
        end
        acc = v && !clr && (m_busy == 0);
        if (acc) begin
            last = nb && (m_bc == WC - 1);
            prod = longint'(d) * longint'(c);
            for (int i = 0; i < 2; i++) begin
                b = (i == 0) ? longint'(bias) : longint'($signed(bias[AW2-1:0]));
                if (!last) begin
                    m_tmp[i] = sadd(i, m_tmp[i] + prod);
                end else begin
                    s = sadd(i, m_tmp[i] + prod);
                    m_tmp[i] = 0;
                    n = sadd(i, m_psum[i][m_ptr] + s);
                    if (m_cnt[i][m_ptr] == SL - 1) begin
                        sc = sadd(i, n + b);
                        m_score[i] = sc;
                        m_msb[i]   = (sc > 0);
                        ed[i]      = 1'b1;
                        m_psum[i][m_ptr] = 0;
                        m_cnt[i][m_ptr]  = 0;
                    end else begin
                        m_psum[i][m_ptr] = n;
                        m_cnt[i][m_ptr]  = m_cnt[i][m_ptr] + 1;
                    end
                end
            end
            if (last) m_ptr = (m_ptr + 1) % WP;
            if (nb)   m_bc  = (m_bc + 1) % WC;
        end
        if (clr) model_wipe();
        for (int i = 0; i < 2; i++) begin
            p_dvo[i]   = ed[i];
            p_sat[i]   = m_sat[i];
            p_score[i] = m_score[i];
            p_msb[i]   = m_msb[i];
        end
        @(posedge clk);
        #1;
        if (clr) m_busy = WP;
        else if (m_busy > 0) m_busy--;
        chk("busy",   longint'(busy),   longint'(m_busy > 0));
        chk("dvo",    longint'(dvo),    longint'(xd[0]));
        chk("score",  longint'(score),  xsc[0]);
        chk("msb",    longint'(msb),    longint'(xm[0]));
        chk("sat",    longint'(sat),    longint'(xs[0]));
        chk("busy12", longint'(busy2),  longint'(m_busy > 0));
        chk("dvo12",  longint'(dvo2),   longint'(xd[1]));
        chk("score12",longint'(score2), xsc[1]);
        chk("msb12",  longint'(msb2),   longint'(xm[1]));
        chk("sat12",  longint'(sat2),   longint'(xs[1]));
        if (dvo)  begin n_dvo++;  last_sc  = longint'(score);  end
        if (dvo2) begin n_dvo2++; last_sc2 = longint'(score2); end
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) cycle(1'b0, 0, 0, 1'b0, 1'b0);
    endtask

    // Whole image rows: WP slices of WC blocks, 4 samples per block, optional idle gap per sample
    task automatic rows(input int nrows, input int d, input int c, input int gap);
        for (int r = 0; r < nrows; r++)
            for (int sl = 0; sl < WP; sl++)
                for (int bk = 0; bk < WC; bk++)
                    for (int k = 0; k < 4; k++) begin
                        cycle(1'b1, d, c, k == 3, 1'b0);
                        idle(gap);
                    end
        idle(3);
    endtask

    int bcnt;
    int d0;

    initial begin
        model_wipe();
        for (int i = 0; i < 2; i++) begin
            m_score[i] = 0; m_msb[i] = 1'b0;
            p_dvo[i] = 1'b0; p_score[i] = 0; p_msb[i] = 1'b0; p_sat[i] = 1'b0;
        end

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy",  longint'(busy),  1);
        chk("rst_dvo",   longint'(dvo),   0);
        chk("rst_score", longint'(score), 0);
        chk("rst_msb",   longint'(msb),   0);
        chk("rst_sat",   longint'(sat),   0);
        @(negedge clk);
        reset_n = 1'b1;

        // 1: busy lasts WP cycles after reset release
        bcnt = int'(busy);
        for (int k = 0; k < 5; k++) begin
            idle(1);
            bcnt += int'(busy);
        end
        chk("s1_busy_cycles", bcnt, WP);

        // 2: positive scores
        bias = -10;
        d0 = n_dvo;
        rows(2, 1, 1, 0);
        chk("s2_pulses", n_dvo - d0, 3);
        chk("s2_score",  last_sc, 6);

        // 3: negative scores, then again to show emitted entries were zeroed
        bias = 0;
        idle(2);
        d0 = n_dvo;
        rows(2, 1, -1, 0);
        chk("s3_score_a", last_sc, -16);
        rows(2, 1, -1, 0);
        chk("s3_pulses", n_dvo - d0, 6);
        chk("s3_score_b", last_sc, -16);

        // 4: saturation on the 12-bit instance, then clear (twice, restarting the sweep)
        rows(2, 255, 255, 0);
        chk("s4_sat12",   longint'(sat2), 1);
        chk("s4_score12", last_sc2, 2047);
        chk("s4_score32", last_sc, 1040400);
        cycle(1'b0, 0, 0, 1'b0, 1'b1);
        chk("s4_sat_clr", longint'(sat2), 0);
        idle(1);
        cycle(1'b0, 0, 0, 1'b0, 1'b1);
        idle(WP);

        // 5: clear colliding with a newblock sample mid-row
        bias = -10;
        idle(1);
        d0 = n_dvo;
        for (int k = 0; k < 11; k++) cycle(1'b1, 1, 1, (k % 4) == 3, 1'b0);
        cycle(1'b1, 1, 1, 1'b1, 1'b1);
        idle(WP + 1);
        rows(2, 1, 1, 0);
        chk("s5_pulses", n_dvo - d0, 3);
        chk("s5_score",  last_sc, 6);

        // 6: 1-of-3 duty on dvi
        d0 = n_dvo;
        rows(2, 1, 1, 2);
        chk("s6_pulses", n_dvo - d0, 3);
        chk("s6_score",  last_sc, 6);

        // 7: random stream
        cycle(1'b0, 0, 0, 1'b0, 1'b1);
        idle(WP);
        bias = $signed(32'($urandom_range(0, 200))) - 100;
        for (int k = 0; k < 300; k++) begin
            if ($urandom_range(0, 3) != 0)
                cycle(1'b1, int'($urandom_range(0, 255)), int'($urandom_range(0, 511)) - 256,
                      $urandom_range(0, 2) == 0, 1'b0);
            else
                idle(1);
        end
        idle(4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
